lfsr_seq_ctrl: RTL and testbench
================================

// Module: lfsr_seq_ctrl
// PURPOSE
//  Upstream control stage for the LFSR counter. Takes a one-cycle start command with seed and target.
//  Drives the counter's data/count_to/load/cen inputs: one load pulse, then counting.
//  Watches the counter state (lfsr_q) fed back from the counter and stops counting on a match.
//  Reports done/timeout/error status and the number of enabled steps taken.
// PARAMETERS
//  width    4          LFSR/counter word width
//  TIMEOUT  2**width   max cen-high cycles in RUN before abort
// PORTS
//  clk       in   1        single clock; all state updates on rising edge
//  reset     in   1        asynchronous, active-low; clears all state
//  start     in   1        command strobe, sampled only in IDLE
//  seed      in   width    initial LFSR value, captured on accepted start
//  target    in   width    stop value, captured on accepted start
//  pause     in   1        freezes counting while high (RUN only)
//  lfsr_q    in   width    current counter state, from the LFSR counter output
//  data      out  width    seed presented to counter (registered)
//  count_to  out  width    target presented to counter (registered)
//  load      out  1        one-cycle load strobe to counter
//  cen       out  1        count enable to counter
//  busy      out  1        high from accepted start until return to IDLE
//  done      out  1        one-cycle pulse: target reached
//  timeout   out  1        one-cycle pulse: TIMEOUT steps without match
//  err_seed  out  1        one-cycle pulse: start rejected, seed == 0 (lock-up state)
//  steps     out  width+1  enabled cycles counted in RUN; held until next start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE. All outputs read 0: data, count_to, load, cen, busy, done, timeout, err_seed, steps.
//  States: IDLE -> LOAD -> RUN -> FIN -> IDLE.
//  IDLE:
//   - start=1, seed!=0: capture seed->data and target->count_to; steps<=0; go to LOAD.
//   - start=1, seed==0: pulse err_seed next cycle; stay IDLE; data/count_to unchanged.
//  LOAD: load=1 and cen=0 for exactly one cycle; then RUN.
//  RUN (cen is combinational):
//   - cen = !pause && (lfsr_q != count_to) && (steps != TIMEOUT).
//   - Each cycle with cen=1: steps <= steps+1.
//   - lfsr_q == count_to: go to FIN; done pulses in FIN.
//   - else steps == TIMEOUT: go to FIN; timeout pulses in FIN.
//   - Match has priority over timeout when both hold in the same cycle.
//  FIN: busy=1, load=0, cen=0; exactly one of done/timeout high for this single cycle; then IDLE.
//  Latency: start accepted at edge N -> load high in cycle N+1 -> cen may first rise in cycle N+2.
//  busy is registered: high in LOAD, RUN and FIN.
//  Boundary cases:
//   - start while busy: ignored; no capture, no status.
//   - seed == target: match seen in the first RUN cycle; cen never rises; done with steps=0.
//   - pause held in LOAD: no effect; load still pulses.
//   - pause in RUN: steps frozen; timeout count frozen.
//   - pause and match in the same cycle: match wins, go to FIN.
//   - reset mid-RUN: cen and load drop immediately (async); steps cleared.
//  Width: steps is width+1 bits so TIMEOUT=2**width fits without wrap; steps never exceeds TIMEOUT.
// STRUCTURE
//  Shared include lfsr_defs.vh holds:
//   - state encoding localparams ST_IDLE/ST_LOAD/ST_RUN/ST_FIN, 2-bit binary;
//   - default width=4, shared with the LFSR counter and its bench.
//  One natural sub-module: lfsr_step_cnt, a width+1 counter with enable, sync clear and at_limit flag.
//  FSM, capture registers and status pulses stay in this module.
// TESTING (bench instantiates this block driving the existing LFSR counter; width=4; clk period 2)
//  1. Reset: hold reset=0 for 2 cycles with start=1 -> all outputs 0, no load pulse.
//     Release reset -> IDLE; start is then accepted.
//  2. Nominal: seed=4'b0111, target=4'b1100, start 1 cycle.
//     -> load=1 exactly one cycle later; cen rises the next cycle.
//     -> done pulses once when lfsr_q==4'b1100; steps equals the model's step count; busy falls after FIN.
//  3. seed=target=4'b0101 -> load pulse, cen stays 0, done pulse, steps=0.
//  4. Timeout: bench forces lfsr_q=4'b0001, target=4'b1100.
//     -> cen high exactly 16 cycles, timeout pulse, steps=16, done never asserted.
//  5. Pause and ignored start:
//     - pause high 5 cycles mid-RUN -> cen=0 and steps frozen throughout; final steps unchanged vs run 2.
//     - start with seed=4'b0011 while busy -> ignored; data stays 4'b0111.
//  6. Error and async reset:
//     - seed=4'b0000 start -> err_seed pulse, no load, busy stays 0.
//     - async reset pulse mid-RUN (off clock edge) -> cen/busy/steps 0 immediately.

Source files
------------

// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared definitions for the LFSR sequencing controller: state encoding and default word width.
`timescale 1ns/1ps
package lfsr_seq_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/lfsr_step_cnt.sv
// Step counter: counts enabled cycles, cleared synchronously, flags when the limit is reached.
`timescale 1ns/1ps
module lfsr_step_cnt #(
  parameter int               cnt_w = 5,
  parameter logic [cnt_w-1:0] limit = 5'd16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [cnt_w-1:0] cnt,
  output logic             at_limit
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Control stage for the LFSR counter: loads a seed, counts until the counter reaches the
// target or the step budget runs out, then reports done/timeout/err_seed and the step count.
`timescale 1ns/1ps
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int width   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 2**width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] seed,
  input  logic [width-1:0] target,
  input  logic             pause,
  input  logic [width-1:0] lfsr_q,
  output logic [width-1:0] data,
  output logic [width-1:0] count_to,
  output logic             load,
  output logic             cen,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err_seed,
  output logic [width:0]   steps,
  output logic [1:0]       dbg_state
);

  localparam logic [width:0] LIMIT = (width+1)'(TIMEOUT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       accept;
  logic       match;
  logic       at_limit;

  // A zero seed would lock the LFSR, so such a start is refused instead of accepted.
  assign accept = (state == ST_IDLE) && start && (seed != '0);
  assign match  = (lfsr_q == count_to);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (match || at_limit) state_nxt = ST_FIN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      data     <= '0;
      count_to <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      err_seed <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data     <= seed;
        count_to <= target;
      end
      // Match outranks the step budget when both are seen in the same RUN cycle.
      done     <= (state == ST_RUN) && match;
      timeout  <= (state == ST_RUN) && !match && at_limit;
      err_seed <= (state == ST_IDLE) && start && (seed == '0);
    end
  end

  assign load      = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign cen       = (state == ST_RUN) && !pause && !match && !at_limit;
  assign dbg_state = state;

  lfsr_step_cnt #(
    .cnt_w (width + 1),
    .limit (LIMIT)
  ) u_step_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .en       (cen),
    .cnt      (steps),
    .at_limit (at_limit)
  );

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl driving a behavioural 4-bit LFSR counter; status pulses are
// checked against a queue of expected outcomes computed from a reference walk of the sequence.
`timescale 1ns/1ps
module tb_lfsr_seq_ctrl;

  localparam int W = 4;
  localparam int TMO = 16;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_TMO  = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] seed;
  logic [W-1:0] target;
  logic         pause;
  logic         pause_dir;
  logic         pause_rnd = 1'b0;
  logic         rand_pause;
  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_r;
  logic         force_en;
  logic [W-1:0] force_val;
  logic [W-1:0] data;
  logic [W-1:0] count_to;
  logic         load;
  logic         cen;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         err_seed;
  logic [W:0]   steps;
  logic [1:0]   dbg_state;

  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #1 clk = ~clk;

  lfsr_seq_ctrl #(.width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed      (seed),
    .target    (target),
    .pause     (pause),
    .lfsr_q    (lfsr_q),
    .data      (data),
    .count_to  (count_to),
    .load      (load),
    .cen       (cen),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .err_seed  (err_seed),
    .steps     (steps),
    .dbg_state (dbg_state)
  );

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  // Behavioural LFSR counter the controller drives; force_en pins its output for the timeout case.
  always @(posedge clk or negedge reset) begin
    if (!reset)      lfsr_r <= 4'b0001;
    else if (load)   lfsr_r <= data;
    else if (cen)    lfsr_r <= lfsr_next(lfsr_r);
  end
  assign lfsr_q = force_en ? force_val : lfsr_r;
  assign pause  = pause_dir | pause_rnd;

  always @(negedge clk) begin
    if (rand_pause) pause_rnd = ($urandom_range(0, 3) == 0);
    else            pause_rnd = 1'b0;
  end

  // Reference outcome: walk the LFSR sequence from seed until target or the step budget.
  function automatic logic [6:0] model_run(input logic [W-1:0] s, input logic [W-1:0] t);
    logic [W-1:0] v;
    int n;
    v = s;
    n = 0;
    while (v != t && n < TMO) begin
      v = lfsr_next(v);
      n++;
    end
    if (v == t) return {K_DONE, 5'(n)};
    return {K_TMO, 5'(n)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Monitor: every status pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [1:0] kind;
    logic [6:0] e;
    if (reset && (done || timeout || err_seed)) begin
      check("status_onehot", 32'(done) + 32'(timeout) + 32'(err_seed), 1);
      kind = done ? K_DONE : (timeout ? K_TMO : K_ERR);
      if (exp_q.size() == 0) begin
        check("status_unexpected", {30'd0, kind}, 0);
      end else begin
        e = exp_q.pop_front();
        check("status_kind", {30'd0, kind}, {30'd0, e[6:5]});
        if (kind != K_ERR) check("status_steps", {27'd0, steps}, {27'd0, e[4:0]});
      end
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after the start edge.
  task automatic issue_start(input logic [W-1:0] s, input logic [W-1:0] t, input bit forced);
    if (s == '0)   exp_q.push_back({K_ERR, 5'd0});
    else if (forced) exp_q.push_back({K_TMO, 5'(TMO)});
    else           exp_q.push_back(model_run(s, t));
    start  = 1'b1;
    seed   = s;
    target = t;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_idle(output int cen_cnt);
    int i;
    cen_cnt = 0;
    for (i = 0; i < 200; i++) begin
      if (!busy) break;
      if (cen) cen_cnt++;
      @(negedge clk);
    end
    check("idle_reached", {31'd0, busy}, 0);
  endtask

  initial begin
    int c;
    reset = 1'b0; start = 1'b1; seed = 4'b0111; target = 4'b1100;
    pause_dir = 1'b0; rand_pause = 1'b0; force_en = 1'b0; force_val = '0;

    // Reset held with start high: everything stays zero.
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs",
            {13'd0, data, count_to, load, cen, busy, done, timeout, err_seed, steps},
            0);
      check("reset_state", {30'd0, dbg_state}, 0);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Nominal run with latency checks.
    issue_start(4'b0111, 4'b1100, 0);
    check("load_cycle", {28'd0, load, cen, busy, 1'b0}, {28'd0, 4'b1010});
    check("captured", {24'd0, data, count_to}, {24'd0, 4'b0111, 4'b1100});
    @(negedge clk);
    check("cen_rise", {30'd0, load, cen}, {30'd0, 2'b01});
    check("first_steps", {27'd0, steps}, 0);
    run_to_idle(c);
    check("nominal_cen_cycles", c, 3);

    // Pause mid-run, plus a start while busy that must be ignored.
    issue_start(4'b0111, 4'b1100, 0);
    @(negedge clk);
    @(negedge clk);
    pause_dir = 1'b1;
    #0.2;
    check("pause_cen", {31'd0, cen}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pause_cen", {31'd0, cen}, 0);
      check("pause_steps", {27'd0, steps}, 1);
      if (i == 1) begin start = 1'b1; seed = 4'b0011; target = 4'b0000; end
      if (i == 2) begin
        start = 1'b0;
        check("busy_start_ignored", {28'd0, data}, {28'd0, 4'b0111});
      end
    end
    pause_dir = 1'b0;
    run_to_idle(c);
    check("pause_data_kept", {28'd0, data}, {28'd0, 4'b0111});

    // Seed equals target: done with zero steps, cen never rises.
    issue_start(4'b0101, 4'b0101, 0);
    check("eq_load", {31'd0, load}, 1);
    run_to_idle(c);
    check("eq_cen_cycles", c, 0);

    // Counter output pinned: the step budget expires.
    force_en = 1'b1; force_val = 4'b0001;
    issue_start(4'b0111, 4'b1100, 1);
    run_to_idle(c);
    check("timeout_cen_cycles", c, TMO);
    force_en = 1'b0;

    // Zero seed rejected.
    issue_start(4'b0000, 4'b1100, 0);
    check("err_no_load", {30'd0, load, busy}, 0);
    @(negedge clk);
    check("err_no_load", {30'd0, load, busy}, 0);
    check("err_data_kept", {28'd0, data}, {28'd0, 4'b0111});

    // Asynchronous reset partway through a run.
    issue_start(4'b0111, 4'b1011, 0);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 1);
    #0.5 reset = 1'b0;
    #0.2;
    check("async_reset", {24'd0, cen, busy, load, steps}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Randomized runs with random pause activity.
    rand_pause = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue_start(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
      run_to_idle(c);
      @(negedge clk);
    end
    rand_pause = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
